// File: rtl/prio_encoder_arb_if.sv
// Request/result bundle for prio_encoder_arb: request vector in, registered
// winner out with a valid/ready handshake.
interface prio_encoder_arb_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic [N-1:0]  out_onehot;
  logic          out_multi;

  modport master (
    output req, out_ready,
    input  out_valid, out_idx, out_onehot, out_multi
  );

  modport slave (
    input  req, out_ready,
    output out_valid, out_idx, out_onehot, out_multi
  );
endinterface

// File: rtl/prio_encoder_arb.sv
// Registered N-to-log2(N) priority encoder with optional round-robin rotation,
// one-hot grant, multiple-request flag and a stalling valid/ready output.
module prio_encoder_arb #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input  logic               clk,
  input  logic               rst,
  prio_encoder_arb_if.slave  bus
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] top_q, top_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic          valid_q, valid_d;
  logic          multi_q, multi_d;

  logic [N-1:0]  low_mask;
  logic [N-1:0]  low_req;
  logic [IW-1:0] win;
  logic          load;
  logic          any_req;

  // Bits at or below the pointer are searched first; the rest only if none of those is set.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign low_mask[gi] = (IW'(gi) <= top_q);
  end

  assign low_req = bus.req & low_mask;
  assign any_req = |bus.req;
  assign load    = !valid_q || bus.out_ready;

  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) win = i[IW-1:0];
    end
    for (int i = 0; i < N; i++) begin
      if (low_req[i]) win = i[IW-1:0];
    end
  end

  always_comb begin
    top_d    = top_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    multi_d  = multi_q;
    if (load) begin
      if (any_req) begin
        valid_d  = 1'b1;
        idx_d    = win;
        onehot_d = N'(1) << win;
        multi_d  = |(bus.req & (bus.req - N'(1)));
        if (RR != 0) begin
          top_d = (win == '0) ? IW'(N - 1) : win - IW'(1);
        end
      end else begin
        valid_d  = 1'b0;
        onehot_d = '0;
        multi_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q    <= IW'(N - 1);
      idx_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      top_q    <= top_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_multi  = multi_q;
endmodule

// File: tb/tb_prio_encoder_arb.sv
// Directed bench for prio_encoder_arb: fixed priority (N=8), round-robin (N=8)
// and round-robin with a non-power-of-two width (N=5), sharing clk and rst.
module tb_prio_encoder_arb;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  prio_encoder_arb_if #(.N(8)) bf ();
  prio_encoder_arb_if #(.N(8)) br ();
  prio_encoder_arb_if #(.N(5)) bp ();

  prio_encoder_arb #(.N(8), .RR(0)) u_fixed (.clk(clk), .rst(rst), .bus(bf.slave));
  prio_encoder_arb #(.N(8), .RR(1)) u_rr8   (.clk(clk), .rst(rst), .bus(br.slave));
  prio_encoder_arb #(.N(5), .RR(1)) u_rr5   (.clk(clk), .rst(rst), .bus(bp.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Still inside the power-on reset
    n_cmp++; if (br.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", br.out_valid); end
    n_cmp++; if (br.out_idx !== 3'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", br.out_idx); end
    n_cmp++; if (br.out_onehot !== 8'h00) begin n_bad++; $display("FAIL rst_onehot: got %h want 00", br.out_onehot); end
    n_cmp++; if (br.out_multi !== 1'b0) begin n_bad++; $display("FAIL rst_multi: got %b want 0", br.out_multi); end
    br.req = 8'hFF; br.out_ready = 1'b1;
    rst = 1'b0;
    step();
    n_cmp++; if (br.out_idx !== 3'd7 || br.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_cap: got idx=%0d v=%b want idx=7 v=1", br.out_idx, br.out_valid); end
    step();
    n_cmp++; if (br.out_idx !== 3'd6) begin n_bad++; $display("FAIL rst_second_cap: got %0d want 6", br.out_idx); end
    // Mid-stream reset must clear outputs before any clock edge
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (br.out_valid !== 1'b0 || br.out_onehot !== 8'h00 || br.out_idx !== 3'd0 || br.out_multi !== 1'b0) begin
      n_bad++; $display("FAIL rst_async: got v=%b idx=%0d oh=%h m=%b want all 0", br.out_valid, br.out_idx, br.out_onehot, br.out_multi);
    end
    #2 rst = 1'b0;
    step();
    n_cmp++; if (br.out_idx !== 3'd7) begin n_bad++; $display("FAIL rst_ptr_restore: got %0d want 7", br.out_idx); end
  endtask

  task automatic test_fixed();
    bf.out_ready = 1'b1;
    bf.req = 8'hA5;
    step();
    n_cmp++; if (bf.out_valid !== 1'b1) begin n_bad++; $display("FAIL fix_a5_valid: got %b want 1", bf.out_valid); end
    n_cmp++; if (bf.out_idx !== 3'd7) begin n_bad++; $display("FAIL fix_a5_idx: got %0d want 7", bf.out_idx); end
    n_cmp++; if (bf.out_onehot !== 8'h80) begin n_bad++; $display("FAIL fix_a5_onehot: got %h want 80", bf.out_onehot); end
    n_cmp++; if (bf.out_multi !== 1'b1) begin n_bad++; $display("FAIL fix_a5_multi: got %b want 1", bf.out_multi); end
    bf.req = 8'h04;
    step();
    n_cmp++; if (bf.out_idx !== 3'd2) begin n_bad++; $display("FAIL fix_04_idx: got %0d want 2", bf.out_idx); end
    n_cmp++; if (bf.out_onehot !== 8'h04) begin n_bad++; $display("FAIL fix_04_onehot: got %h want 04", bf.out_onehot); end
    n_cmp++; if (bf.out_multi !== 1'b0) begin n_bad++; $display("FAIL fix_04_multi: got %b want 0", bf.out_multi); end
    // Fixed mode never rotates: repeating a multi-request yields the same winner
    bf.req = 8'h5A;
    step();
    n_cmp++; if (bf.out_idx !== 3'd6) begin n_bad++; $display("FAIL fix_5a_idx0: got %0d want 6", bf.out_idx); end
    step();
    n_cmp++; if (bf.out_idx !== 3'd6) begin n_bad++; $display("FAIL fix_5a_idx1: got %0d want 6", bf.out_idx); end
    bf.req = 8'h00;
    step();
    n_cmp++; if (bf.out_valid !== 1'b0 || bf.out_idx !== 3'd6 || bf.out_onehot !== 8'h00) begin
      n_bad++; $display("FAIL fix_empty: got v=%b idx=%0d oh=%h want v=0 idx=6 oh=00", bf.out_valid, bf.out_idx, bf.out_onehot);
    end
  endtask

  task automatic test_rr_full();
    int exp_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    logic [2:0] e_idx;
    logic [7:0] e_oh;
    br.req = 8'hFF; br.out_ready = 1'b1;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      e_idx = exp_seq[k][2:0];
      e_oh  = 8'h01 << e_idx;
      n_cmp++; if (br.out_idx !== e_idx || br.out_onehot !== e_oh || br.out_multi !== 1'b1 || br.out_valid !== 1'b1) begin
        n_bad++; $display("FAIL rr_full[%0d]: got idx=%0d oh=%h m=%b v=%b want idx=%0d oh=%h m=1 v=1",
                          k, br.out_idx, br.out_onehot, br.out_multi, br.out_valid, e_idx, e_oh);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq [4] = '{4, 1, 4, 1};
    logic [2:0] e_idx;
    br.req = 8'h12;
    for (int k = 0; k < 4; k++) begin
      step();
      e_idx = exp_seq[k][2:0];
      n_cmp++; if (br.out_idx !== e_idx) begin n_bad++; $display("FAIL rr_sparse[%0d]: got %0d want %0d", k, br.out_idx, e_idx); end
    end
  endtask

  task automatic test_stall();
    br.req = 8'h20; br.out_ready = 1'b1;
    step();
    n_cmp++; if (br.out_idx !== 3'd5 || br.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_cap: got idx=%0d v=%b want idx=5 v=1", br.out_idx, br.out_valid); end
    br.out_ready = 1'b0;
    br.req = 8'h01;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (br.out_idx !== 3'd5 || br.out_valid !== 1'b1 || br.out_onehot !== 8'h20 || br.out_multi !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got idx=%0d v=%b oh=%h m=%b want idx=5 v=1 oh=20 m=0",
                          k, br.out_idx, br.out_valid, br.out_onehot, br.out_multi);
      end
    end
    br.out_ready = 1'b1;
    step();
    n_cmp++; if (br.out_idx !== 3'd0 || br.out_onehot !== 8'h01) begin n_bad++; $display("FAIL stall_release: got idx=%0d oh=%h want idx=0 oh=01", br.out_idx, br.out_onehot); end
    // Pointer wrapped to 7 after winner 0: bits 5 and 3 -> 5
    br.req = 8'h28;
    step();
    n_cmp++; if (br.out_idx !== 3'd5) begin n_bad++; $display("FAIL stall_ptr: got %0d want 5", br.out_idx); end
  endtask

  task automatic test_npot();
    int exp_seq [4] = '{4, 0, 4, 0};
    logic [2:0] e_idx;
    bp.req = 5'b10001; bp.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      e_idx = exp_seq[k][2:0];
      n_cmp++; if (bp.out_idx !== e_idx || bp.out_valid !== 1'b1) begin
        n_bad++; $display("FAIL npot[%0d]: got idx=%0d v=%b want idx=%0d v=1", k, bp.out_idx, bp.out_valid, e_idx);
      end
    end
    bp.req = 5'b00000;
    step();
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL npot_empty_valid: got %b want 0", bp.out_valid); end
    n_cmp++; if (bp.out_idx !== 3'd0) begin n_bad++; $display("FAIL npot_empty_idx: got %0d want 0", bp.out_idx); end
    n_cmp++; if (bp.out_onehot !== 5'b00000 || bp.out_multi !== 1'b0) begin n_bad++; $display("FAIL npot_empty_oh: got oh=%b m=%b want 00000 0", bp.out_onehot, bp.out_multi); end
    // Empty load leaves the pointer at 4, so the wrap from 0 still picks 4 next
    bp.req = 5'b10001;
    step();
    n_cmp++; if (bp.out_idx !== 3'd4 || bp.out_onehot !== 5'b10000) begin n_bad++; $display("FAIL npot_resume: got idx=%0d oh=%b want idx=4 oh=10000", bp.out_idx, bp.out_onehot); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bf.req = '0; bf.out_ready = 1'b0;
    br.req = '0; br.out_ready = 1'b0;
    bp.req = '0; bp.out_ready = 1'b0;
    step();
    step();
    test_reset();
    test_fixed();
    test_rr_full();
    test_rr_sparse();
    test_stall();
    test_npot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
